game_flow_ctrl: RTL and testbench
=================================

// Module: game_flow_ctrl
// PURPOSE
//  Top-level game sequencer. Drives RoomNum for the start-screen logo renderer, the room renderers and the color mapper.
//  Walks START -> ENTER -> PLAY -> DYING/ENTER -> GAME_OVER -> START.
//  Debounces the start key and counts lives. Commits every room change on a frame boundary, so the display never tears mid-frame.
// PARAMETERS
//  NUM_LEVELS      3   playable rooms 0..NUM_LEVELS-1 (max 6; room 6 = game over, room 7 = start screen)
//  START_LIVES     3   lives loaded on new game (1..3)
//  ENTRY_FRAMES    60  frames frozen on level entry before play
//  DEATH_FRAMES    90  frames frozen after death
//  OVER_FRAMES     180 frames the game-over room is shown
//  BLINK_FRAMES    30  half-period of "press start" prompt blink
//  DEBOUNCE_FRAMES 3   consecutive frame samples required to change key level
// PORTS
//  Clk               in  1  system clock
//  Reset_n           in  1  asynchronous active-low reset
//  frame_tick        in  1  1-cycle pulse per vsync (frame boundary)
//  start_key         in  1  raw start button level (1 = pressed)
//  player_died       in  1  1-cycle pulse from game logic
//  level_done        in  1  1-cycle pulse from game logic (flag reached)
//  RoomNum           out 3  current room: 0..NUM_LEVELS-1 levels, 6 game over, 7 start
//  game_active       out 1  1 only in PLAY (game logic may move sprites)
//  freeze            out 1  1 in ENTER and DYING
//  show_prompt       out 1  blink enable for start-screen prompt
//  lives             out 2  remaining lives
// BEHAVIOUR
//  Reset (async, Reset_n=0):
//   - state=START, RoomNum=7, lives=START_LIVES, game_active=0, freeze=0, show_prompt=1.
//   - All counters 0; pending flags, debounce state and key edge cleared.
//  Outputs: all outputs are registered and decoded from the state/level registers.
//  Frame-boundary rule: state, RoomNum and counters update only in cycles with frame_tick=1. Changes are visible the cycle after.
//  Event latching:
//   - player_died / level_done pulses in PLAY set sticky pending flags; these are consumed at the next frame_tick.
//   - If both are pending, death wins and level_done is dropped.
//   - Pulses outside PLAY are ignored.
//  Debounce:
//   - start_key is sampled on each frame_tick. The debounced level flips after DEBOUNCE_FRAMES equal consecutive samples that differ from it.
//   - press = 0->1 transition of the debounced level. A key held across states does not generate a new press.
//  FSM (frame_cnt counts ticks within a state; cleared on every state change):
//   - START: RoomNum=7.
//     - show_prompt toggles every BLINK_FRAMES ticks.
//     - On press: lives=START_LIVES, level=0 -> ENTER.
//   - ENTER: RoomNum=level, freeze=1. After ENTRY_FRAMES ticks -> PLAY.
//   - PLAY: game_active=1.
//     - Death pending -> DYING.
//     - Else level_done pending:
//       - level<NUM_LEVELS-1: level+1 -> ENTER.
//       - Last level: -> START (win).
//   - DYING: freeze=1, RoomNum unchanged. After DEATH_FRAMES ticks:
//     - lives>1: lives-1 -> ENTER (same level).
//     - Else: lives=0 -> GAME_OVER.
//   - GAME_OVER: RoomNum=6. After OVER_FRAMES ticks -> START (lives reload on next press).
//  show_prompt:
//   - Forced to 1 on entering START.
//   - Outside START it holds 0.
//  Widths:
//   - frame_cnt is wide enough for max(ENTRY,DEATH,OVER,BLINK) frames and saturates rather than wraps.
//   - lives never underflows.
//  Reset mid-operation returns to START within the same cycle (async). There is no resume.
// TESTING
//  1. Reset, hold start_key=0 for 70 ticks:
//     - RoomNum=7 throughout.
//     - show_prompt toggles at ticks 30 and 60.
//     - game_active=0.
//  2. start_key=1 for 2 ticks then 0: no transition.
//     start_key=1 for 3 ticks: ENTER (RoomNum=0, freeze=1) after the 3rd tick; PLAY after 60 further ticks.
//  3. In PLAY on level 0, pulse level_done mid-frame:
//     - RoomNum stays 0 until the next frame_tick.
//     - Then RoomNum=1 and freeze=1.
//     - On level 2, level_done -> RoomNum=7.
//  4. Same-frame player_died and level_done in PLAY:
//     - DYING is entered and level is unchanged.
//     - After 90 ticks: lives 3->2, ENTER same room.
//  5. Die with lives=1: GAME_OVER (RoomNum=6, lives=0) for 180 ticks, then START. Holding start_key throughout causes no new game until release and re-press.
//  6. Assert Reset_n=0 during DYING at an arbitrary cycle:
//     - Immediately RoomNum=7, lives=3, freeze=0, game_active=0.
//     - Release and verify a normal start.

Source files
------------

// File: rtl/game_flow_ctrl.sv
// Top-level game sequencer: start screen, level entry, play, death and game over.
// Every state, room and counter change commits on a frame_tick so the display never tears.
module game_flow_ctrl #(
    parameter int unsigned NUM_LEVELS      = 3,
    parameter int unsigned START_LIVES     = 3,
    parameter int unsigned ENTRY_FRAMES    = 60,
    parameter int unsigned DEATH_FRAMES    = 90,
    parameter int unsigned OVER_FRAMES     = 180,
    parameter int unsigned BLINK_FRAMES    = 30,
    parameter int unsigned DEBOUNCE_FRAMES = 3
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_tick,
    input  logic       start_key,
    input  logic       player_died,
    input  logic       level_done,
    output logic [2:0] RoomNum,
    output logic       game_active,
    output logic       freeze,
    output logic       show_prompt,
    output logic [1:0] lives
);

    localparam logic [2:0] S_START = 3'd0;
    localparam logic [2:0] S_ENTER = 3'd1;
    localparam logic [2:0] S_PLAY  = 3'd2;
    localparam logic [2:0] S_DYING = 3'd3;
    localparam logic [2:0] S_OVER  = 3'd4;

    localparam logic [2:0] ROOM_OVER  = 3'd6;
    localparam logic [2:0] ROOM_START = 3'd7;

    localparam int unsigned MAX_ED = (ENTRY_FRAMES > DEATH_FRAMES) ? ENTRY_FRAMES : DEATH_FRAMES;
    localparam int unsigned MAX_OB = (OVER_FRAMES > BLINK_FRAMES) ? OVER_FRAMES : BLINK_FRAMES;
    localparam int unsigned MAX_FR = (MAX_ED > MAX_OB) ? MAX_ED : MAX_OB;
    localparam int unsigned CNT_W  = $clog2(MAX_FR + 1);
    localparam int unsigned DB_W   = $clog2(DEBOUNCE_FRAMES + 1);

    logic [2:0]       state, state_nx;
    logic [2:0]       level, level_nx;
    logic [2:0]       room_nx;
    logic [CNT_W-1:0] frame_cnt, frame_cnt_nx;
    logic [1:0]       lives_nx;
    logic             prompt_nx;

    logic             key_db;
    logic [DB_W-1:0]  db_cnt;
    logic             db_flip;
    logic             press;

    logic             in_play;
    logic             die_pend, done_pend;
    logic             die_now, done_now;

    // ---------------- start key debounce (sampled once per frame) ----------------
    assign db_flip = frame_tick && (start_key != key_db) &&
                     (db_cnt == DB_W'(DEBOUNCE_FRAMES - 1));
    assign press   = db_flip && !key_db;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            key_db <= 1'b0;
            db_cnt <= '0;
        end else if (frame_tick) begin
            if (start_key == key_db) begin
                db_cnt <= '0;
            end else if (db_flip) begin
                key_db <= ~key_db;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // ---------------- sticky game events, consumed at the next frame ----------------
    assign in_play  = (state == S_PLAY);
    // A pulse landing on the tick cycle itself is consumed by that same tick.
    assign die_now  = die_pend  || (in_play && player_died);
    assign done_now = done_pend || (in_play && level_done);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            die_pend  <= 1'b0;
            done_pend <= 1'b0;
        end else if (frame_tick) begin
            die_pend  <= 1'b0;
            done_pend <= 1'b0;
        end else begin
            if (in_play && player_died) die_pend  <= 1'b1;
            if (in_play && level_done)  done_pend <= 1'b1;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_nx     = state;
        level_nx     = level;
        lives_nx     = lives;
        prompt_nx    = show_prompt;
        frame_cnt_nx = (&frame_cnt) ? frame_cnt : frame_cnt + 1'b1;

        case (state)
            S_START: begin
                if (press) begin
                    state_nx = S_ENTER;
                    level_nx = '0;
                    lives_nx = 2'(START_LIVES);
                end else if (frame_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
                    prompt_nx    = ~show_prompt;
                    frame_cnt_nx = '0;
                end
            end
            S_ENTER: begin
                if (frame_cnt == CNT_W'(ENTRY_FRAMES - 1))
                    state_nx = S_PLAY;
            end
            S_PLAY: begin
                if (die_now) begin
                    state_nx = S_DYING;
                end else if (done_now) begin
                    if (level < 3'(NUM_LEVELS - 1)) begin
                        level_nx = level + 3'd1;
                        state_nx = S_ENTER;
                    end else begin
                        state_nx = S_START;
                    end
                end
            end
            S_DYING: begin
                if (frame_cnt == CNT_W'(DEATH_FRAMES - 1)) begin
                    if (lives > 2'd1) begin
                        lives_nx = lives - 2'd1;
                        state_nx = S_ENTER;
                    end else begin
                        lives_nx = 2'd0;
                        state_nx = S_OVER;
                    end
                end
            end
            S_OVER: begin
                if (frame_cnt == CNT_W'(OVER_FRAMES - 1))
                    state_nx = S_START;
            end
            default: begin
                state_nx = S_START;
            end
        endcase

        if (state_nx != state)
            frame_cnt_nx = '0;

        // Prompt is lit whenever START is (re)entered and dark everywhere else.
        if (state_nx != S_START)
            prompt_nx = 1'b0;
        else if (state != S_START)
            prompt_nx = 1'b1;

        case (state_nx)
            S_START: room_nx = ROOM_START;
            S_OVER:  room_nx = ROOM_OVER;
            default: room_nx = level_nx;
        endcase
    end

    // ---------------- registered state and outputs ----------------
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state       <= S_START;
            level       <= '0;
            frame_cnt   <= '0;
            lives       <= 2'(START_LIVES);
            show_prompt <= 1'b1;
            RoomNum     <= ROOM_START;
            game_active <= 1'b0;
            freeze      <= 1'b0;
        end else if (frame_tick) begin
            state       <= state_nx;
            level       <= level_nx;
            frame_cnt   <= frame_cnt_nx;
            lives       <= lives_nx;
            show_prompt <= prompt_nx;
            RoomNum     <= room_nx;
            game_active <= (state_nx == S_PLAY);
            freeze      <= (state_nx == S_ENTER) || (state_nx == S_DYING);
        end
    end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: directed game walk with randomized timing/noise,
// every cycle compared against a frame-level model of the game rules.
module tb_game_flow_ctrl;

    localparam int FRAME_CYC = 4;
    localparam int NUM_LEVELS = 3, START_LIVES = 3, ENTRY = 60, DEATH = 90, OVER = 180;
    localparam int BLINK = 30, DEB = 3;

    logic       Clk, Reset_n, frame_tick, start_key, player_died, level_done;
    logic [2:0] RoomNum;
    logic       game_active, freeze, show_prompt;
    logic [1:0] lives;

    int checks   = 0;
    int failures = 0;

    game_flow_ctrl dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .start_key(start_key),
        .player_died(player_died), .level_done(level_done), .RoomNum(RoomNum),
        .game_active(game_active), .freeze(freeze), .show_prompt(show_prompt), .lives(lives)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // ---------------- reference model (one step per frame) ----------------
    typedef enum {M_START, M_ENTER, M_PLAY, M_DYING, M_OVER} mode_t;
    mode_t m_mode;
    int    m_level, m_lives, m_left, m_blink;
    bit    m_prompt, m_db, m_die, m_done;
    bit    m_hist[$];

    task automatic model_reset();
        m_mode = M_START; m_level = 0; m_lives = START_LIVES; m_left = 0;
        m_blink = BLINK; m_prompt = 1'b1; m_db = 1'b0; m_die = 1'b0; m_done = 1'b0;
        m_hist.delete();
    endtask

    task automatic go_start();
        m_mode = M_START; m_prompt = 1'b1; m_blink = BLINK;
    endtask

    task automatic model_tick(input bit key);
        bit press, all_diff;
        press = 1'b0;
        m_hist.push_back(key);
        if (m_hist.size() > DEB) void'(m_hist.pop_front());
        all_diff = (m_hist.size() == DEB);
        foreach (m_hist[i]) if (m_hist[i] == m_db) all_diff = 1'b0;
        if (all_diff) begin
            m_db  = ~m_db;
            press = m_db;
        end
        case (m_mode)
            M_START: begin
                if (press) begin
                    m_mode = M_ENTER; m_level = 0; m_lives = START_LIVES; m_left = ENTRY;
                end else begin
                    m_blink--;
                    if (m_blink == 0) begin m_prompt = ~m_prompt; m_blink = BLINK; end
                end
            end
            M_ENTER: begin
                m_left--;
                if (m_left == 0) m_mode = M_PLAY;
            end
            M_PLAY: begin
                if (m_die) begin
                    m_mode = M_DYING; m_left = DEATH;
                end else if (m_done) begin
                    if (m_level < NUM_LEVELS - 1) begin
                        m_level++; m_mode = M_ENTER; m_left = ENTRY;
                    end else go_start();
                end
                m_die = 1'b0; m_done = 1'b0;
            end
            M_DYING: begin
                m_left--;
                if (m_left == 0) begin
                    if (m_lives > 1) begin m_lives--; m_mode = M_ENTER; m_left = ENTRY; end
                    else begin m_lives = 0; m_mode = M_OVER; m_left = OVER; end
                end
            end
            M_OVER: begin
                m_left--;
                if (m_left == 0) go_start();
            end
        endcase
    endtask

    // ---------------- comparison helpers ----------------
    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic check_model(input string tag);
        int er;
        er = (m_mode == M_START) ? 7 : (m_mode == M_OVER) ? 6 : m_level;
        chk({tag, ".room"},   {5'd0, RoomNum},     8'(er));
        chk({tag, ".active"}, {7'd0, game_active}, {7'd0, m_mode == M_PLAY});
        chk({tag, ".freeze"}, {7'd0, freeze},      {7'd0, (m_mode == M_ENTER) || (m_mode == M_DYING)});
        chk({tag, ".prompt"}, {7'd0, show_prompt}, {7'd0, (m_mode == M_START) && m_prompt});
        chk({tag, ".lives"},  {6'd0, lives},       8'(m_lives));
    endtask

    // One frame, entered and left at a negedge. die_at/done_at: cycle 1..FRAME_CYC-1, 0 = none.
    // noise adds random event pulses to frames that are not in play (they must be ignored).
    task automatic frame(input bit key, input int die_at, input int done_at, input bit noise);
        frame_tick = 1'b1; start_key = key;
        @(negedge Clk);
        frame_tick = 1'b0;
        model_tick(key);
        check_model("tick");
        if (noise && m_mode != M_PLAY) begin
            die_at  = int'($urandom_range(0, FRAME_CYC - 1));
            done_at = int'($urandom_range(0, FRAME_CYC - 1));
        end
        for (int c = 1; c < FRAME_CYC; c++) begin
            player_died = (c == die_at);
            level_done  = (c == done_at);
            if (m_mode == M_PLAY) begin
                if (c == die_at)  m_die  = 1'b1;
                if (c == done_at) m_done = 1'b1;
            end
            @(negedge Clk);
            player_died = 1'b0; level_done = 1'b0;
            check_model("mid");
        end
    endtask

    task automatic run(input int n, input bit key, input bit noise);
        for (int i = 0; i < n; i++) frame(key, 0, 0, noise);
    endtask

    task automatic play_to_done();
        run(int'($urandom_range(1, 5)), 1'b0, 1'b0);
        frame(1'b0, 0, int'($urandom_range(1, FRAME_CYC - 1)), 1'b0);
    endtask

    task automatic play_to_death();
        run(int'($urandom_range(1, 5)), 1'b0, 1'b0);
        frame(1'b0, int'($urandom_range(1, FRAME_CYC - 1)), 0, 1'b0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        Reset_n = 1'b0; frame_tick = 1'b0; start_key = 1'b0;
        player_died = 1'b0; level_done = 1'b0;
        model_reset();
        repeat (3) @(negedge Clk);
        chk("rst.room", {5'd0, RoomNum}, 8'd7);
        chk("rst.lives", {6'd0, lives}, 8'd3);
        chk("rst.active", {7'd0, game_active}, 8'd0);
        chk("rst.freeze", {7'd0, freeze}, 8'd0);
        chk("rst.prompt", {7'd0, show_prompt}, 8'd1);
        Reset_n = 1'b1;

        // 1: idle start screen, prompt blink
        for (int i = 1; i <= 70; i++) begin
            frame(1'b0, 0, 0, 1'b1);
            if (i == 29) chk("blink29", {7'd0, show_prompt}, 8'd1);
            if (i == 30) chk("blink30", {7'd0, show_prompt}, 8'd0);
            if (i == 60) chk("blink60", {7'd0, show_prompt}, 8'd1);
        end

        // 2: short press ignored, 3-frame press starts
        run(2, 1'b1, 1'b1);
        run(int'($urandom_range(1, 4)), 1'b0, 1'b1);
        chk("short_press.room", {5'd0, RoomNum}, 8'd7);
        run(3, 1'b1, 1'b1);
        chk("start.room", {5'd0, RoomNum}, 8'd0);
        chk("start.freeze", {7'd0, freeze}, 8'd1);
        run(10, 1'b1, 1'b1);
        run(49, 1'b0, 1'b1);
        chk("enter59.freeze", {7'd0, freeze}, 8'd1);
        frame(1'b0, 0, 0, 1'b1);
        chk("play.active", {7'd0, game_active}, 8'd1);

        // 3: level progression, win back to start
        play_to_done();
        chk("done_mid.room", {5'd0, RoomNum}, 8'd0);
        frame(1'b0, 0, 0, 1'b1);
        chk("lvl1.room", {5'd0, RoomNum}, 8'd1);
        chk("lvl1.freeze", {7'd0, freeze}, 8'd1);
        run(60, 1'b0, 1'b1);
        play_to_done();
        frame(1'b0, 0, 0, 1'b1);
        chk("lvl2.room", {5'd0, RoomNum}, 8'd2);
        run(60, 1'b0, 1'b1);
        play_to_done();
        frame(1'b0, 0, 0, 1'b1);
        chk("win.room", {5'd0, RoomNum}, 8'd7);
        chk("win.prompt", {7'd0, show_prompt}, 8'd1);

        // 4: simultaneous death and level_done: death wins
        run(3, 1'b1, 1'b1);
        run(60, 1'b0, 1'b1);
        run(int'($urandom_range(1, 5)), 1'b0, 1'b0);
        frame(1'b0, int'($urandom_range(1, FRAME_CYC - 1)), int'($urandom_range(1, FRAME_CYC - 1)), 1'b0);
        frame(1'b0, 0, 0, 1'b1);
        chk("dying.room", {5'd0, RoomNum}, 8'd0);
        chk("dying.freeze", {7'd0, freeze}, 8'd1);
        run(89, 1'b0, 1'b1);
        chk("dying89.lives", {6'd0, lives}, 8'd3);
        frame(1'b0, 0, 0, 1'b1);
        chk("revive.lives", {6'd0, lives}, 8'd2);
        chk("revive.room", {5'd0, RoomNum}, 8'd0);

        // 5: lose remaining lives, key held through game over
        run(60, 1'b0, 1'b1);
        play_to_death();
        run(91, 1'b0, 1'b1);
        chk("lives1", {6'd0, lives}, 8'd1);
        run(59, 1'b0, 1'b1);
        play_to_death();
        frame(1'b1, 0, 0, 1'b1);
        run(90, 1'b1, 1'b1);
        chk("over.room", {5'd0, RoomNum}, 8'd6);
        chk("over.lives", {6'd0, lives}, 8'd0);
        run(179, 1'b1, 1'b1);
        chk("over179.room", {5'd0, RoomNum}, 8'd6);
        frame(1'b1, 0, 0, 1'b1);
        chk("back_start.room", {5'd0, RoomNum}, 8'd7);
        run(10, 1'b1, 1'b1);
        chk("held_key.room", {5'd0, RoomNum}, 8'd7);
        run(4, 1'b0, 1'b1);
        run(3, 1'b1, 1'b1);
        chk("repress.room", {5'd0, RoomNum}, 8'd0);
        chk("repress.lives", {6'd0, lives}, 8'd3);

        // 6: async reset during DYING
        run(60, 1'b0, 1'b1);
        play_to_death();
        run(int'($urandom_range(1, 80)), 1'b0, 1'b1);
        repeat (int'($urandom_range(0, 3))) @(posedge Clk);
        #2 Reset_n = 1'b0;
        #1;
        chk("async.room", {5'd0, RoomNum}, 8'd7);
        chk("async.lives", {6'd0, lives}, 8'd3);
        chk("async.freeze", {7'd0, freeze}, 8'd0);
        chk("async.active", {7'd0, game_active}, 8'd0);
        model_reset();
        @(negedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        run(5, 1'b0, 1'b1);
        run(3, 1'b1, 1'b1);
        chk("restart.room", {5'd0, RoomNum}, 8'd0);
        chk("restart.freeze", {7'd0, freeze}, 8'd1);
        run(60, 1'b0, 1'b0);
        chk("restart.active", {7'd0, game_active}, 8'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
